// File: rtl/line_clear.sv
// Board compaction engine: after a piece locks, removes full rows bottom-up,
// slides the remaining rows down and zero-fills the rows vacated at the top.
module line_clear (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [5:0] ram_q,
  output logic [7:0] ram_addr,
  output logic [5:0] ram_d,
  output logic       ram_wren,
  output logic       busy,
  output logic       done,
  output logic [4:0] rows_cleared
);

  localparam int unsigned BOARD_W  = 10;
  localparam int unsigned BOARD_H  = 24;
  localparam int unsigned COLOUR_W = 6;
  localparam logic [4:0]  LAST_ROW = 5'(BOARD_H - 1);
  localparam logic [3:0]  LAST_X   = 4'(BOARD_W - 1);
  localparam logic [3:0]  READ_END = 4'(BOARD_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_COPY,
    S_FILL,
    S_DONE
  } state_t;

  state_t              state;
  logic [4:0]          src;
  logic [4:0]          dst;
  logic [3:0]          x;
  logic                full;
  logic [COLOUR_W-1:0] row_buf [BOARD_W];

  // First RAM address of a row.
  function automatic logic [7:0] row_base(input logic [4:0] r);
    return 8'(r) * 8'(BOARD_W);
  endfunction

  // Sequencer: row read/check, row copy, top zero-fill; all outputs registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      ram_addr     <= '0;
      ram_d        <= '0;
      ram_wren     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rows_cleared <= '0;
      src          <= '0;
      dst          <= '0;
      x            <= '0;
      full         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src          <= LAST_ROW;
            dst          <= LAST_ROW;
            rows_cleared <= '0;
            x            <= '0;
            full         <= 1'b1;
            ram_addr     <= row_base(LAST_ROW);
            busy         <= 1'b1;
            state        <= S_READ;
          end
        end

        S_READ: begin
          // Data for address x-1 arrives this cycle.
          if (x != 4'd0) begin
            row_buf[x - 4'd1] <= ram_q;
            full              <= full & (ram_q != '0);
          end
          if (x == READ_END) begin
            x     <= '0;
            state <= S_CHECK;
          end else begin
            x <= x + 4'd1;
            if (x < LAST_X) ram_addr <= ram_addr + 8'd1;
          end
        end

        S_CHECK: begin
          if (full) begin
            rows_cleared <= rows_cleared + 5'd1;
            if (src == 5'd0) begin
              // At least one row cleared: zero-fill from dst down to row 0.
              ram_addr <= row_base(dst);
              ram_d    <= '0;
              ram_wren <= 1'b1;
              x        <= '0;
              state    <= S_FILL;
            end else begin
              src      <= src - 5'd1;
              full     <= 1'b1;
              ram_addr <= row_base(src - 5'd1);
              state    <= S_READ;
            end
          end else if (dst == src) begin
            // Row already in place; nothing cleared so far, so nothing to fill.
            if (src == 5'd0) begin
              state <= S_FILL;
            end else begin
              src      <= src - 5'd1;
              dst      <= dst - 5'd1;
              full     <= 1'b1;
              ram_addr <= row_base(src - 5'd1);
              state    <= S_READ;
            end
          end else begin
            ram_addr <= row_base(dst);
            ram_d    <= row_buf[0];
            ram_wren <= 1'b1;
            x        <= '0;
            state    <= S_COPY;
          end
        end

        S_COPY: begin
          if (x != LAST_X) begin
            x        <= x + 4'd1;
            ram_addr <= ram_addr + 8'd1;
            ram_d    <= row_buf[x + 4'd1];
          end else begin
            dst <= dst - 5'd1;
            x   <= '0;
            if (src == 5'd0) begin
              // dst > src here, so rows dst-1..0 are the vacated ones.
              ram_addr <= row_base(dst - 5'd1);
              ram_d    <= '0;
              state    <= S_FILL;
            end else begin
              src      <= src - 5'd1;
              ram_wren <= 1'b0;
              full     <= 1'b1;
              ram_addr <= row_base(src - 5'd1);
              state    <= S_READ;
            end
          end
        end

        S_FILL: begin
          if (rows_cleared == 5'd0) begin
            ram_wren <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else if (x != LAST_X) begin
            x        <= x + 4'd1;
            ram_addr <= ram_addr + 8'd1;
          end else if (dst == 5'd0) begin
            ram_wren <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            dst      <= dst - 5'd1;
            x        <= '0;
            ram_addr <= row_base(dst - 5'd1);
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: behavioural RAM plus a row-list reference model.
module tb_line_clear;

  localparam int W = 10;
  localparam int H = 24;
  localparam int LIMIT = 2000;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [5:0] ram_q;
  logic [7:0] ram_addr;
  logic [5:0] ram_d;
  logic       ram_wren;
  logic       busy;
  logic       done;
  logic [4:0] rows_cleared;

  logic       ld_en;
  logic [7:0] ld_addr;
  logic [5:0] ld_d;
  logic [5:0] mem [W*H];

  logic [5:0] init_b [H][W];
  logic [5:0] exp_b  [H][W];
  int         exp_cleared;
  int         exp_writes;

  int tests;
  int fails;

  line_clear dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .ram_q        (ram_q),
    .ram_addr     (ram_addr),
    .ram_d        (ram_d),
    .ram_wren     (ram_wren),
    .busy         (busy),
    .done         (done),
    .rows_cleared (rows_cleared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port board RAM with a bench-side load port.
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_d;
    else if (ram_wren && ram_addr < 8'(W*H)) mem[ram_addr] <= ram_d;
    ram_q <= (ram_addr < 8'(W*H)) ? mem[ram_addr] : 6'd0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_mem_row(input int y);
    logic [63:0] v = '0;
    for (int i = 0; i < W; i++) v[i*6 +: 6] = mem[y*W + i];
    return v;
  endfunction

  function automatic logic [63:0] pack_exp_row(input int y);
    logic [63:0] v = '0;
    for (int i = 0; i < W; i++) v[i*6 +: 6] = exp_b[y][i];
    return v;
  endfunction

  // Reference: keep non-full rows in bottom-up order, stack them from row 23 down.
  task automatic build_model();
    int keep[$];
    bit f;
    keep.delete();
    exp_cleared = 0;
    for (int y = H - 1; y >= 0; y--) begin
      f = 1'b1;
      for (int i = 0; i < W; i++) if (init_b[y][i] == 6'd0) f = 1'b0;
      if (f) exp_cleared++;
      else keep.push_back(y);
    end
    for (int y = 0; y < H; y++)
      for (int i = 0; i < W; i++) exp_b[y][i] = 6'd0;
    exp_writes = exp_cleared * W;
    for (int k = 0; k < keep.size(); k++) begin
      for (int i = 0; i < W; i++) exp_b[H-1-k][i] = init_b[keep[k]][i];
      if (keep[k] != H - 1 - k) exp_writes += W;
    end
  endtask

  task automatic clear_init();
    for (int y = 0; y < H; y++)
      for (int i = 0; i < W; i++) init_b[y][i] = 6'd0;
  endtask

  task automatic fill_row(input int y, input logic [5:0] c);
    for (int i = 0; i < W; i++) init_b[y][i] = c;
  endtask

  task automatic load_board();
    for (int y = 0; y < H; y++)
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 8'(y*W + i);
        ld_d    = init_b[y][i];
      end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check_board(input string name);
    for (int y = 0; y < H; y++)
      check($sformatf("%s_row%0d", name, y), pack_mem_row(y), pack_exp_row(y));
  endtask

  // Start one run, wait for done (bounded), then check results.
  task automatic run(input string name, input bit hold, input int exp_cycles);
    int n;
    int wr;
    build_model();
    load_board();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    n  = 1;
    wr = ram_wren ? 1 : 0;
    check({name, "_busy_rise"}, 64'(busy), 64'd1);
    if (!hold) start = 1'b0;
    while (!done && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (ram_wren) wr++;
    end
    check({name, "_done_seen"}, 64'(done), 64'd1);
    check({name, "_busy_at_done"}, 64'(busy), 64'd1);
    if (exp_cycles > 0) check({name, "_cycles"}, 64'(n), 64'(exp_cycles));
    else check({name, "_cycle_bound"}, 64'(n < H*22 + H*W + 2), 64'd1);
    check({name, "_rows_cleared"}, 64'(rows_cleared), 64'(exp_cleared));
    check({name, "_write_cycles"}, 64'(wr), 64'(exp_writes));
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done), 64'd0);
    check({name, "_busy_fall"}, 64'(busy), 64'd0);
    check({name, "_rc_hold"}, 64'(rows_cleared), 64'(exp_cleared));
    check_board(name);
  endtask

  initial begin
    int n;
    tests  = 0;
    fails  = 0;
    resetn = 1'b0;
    start  = 1'b0;
    ld_en  = 1'b0;
    ld_addr = '0;
    ld_d    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wren", 64'(ram_wren), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_rc", 64'(rows_cleared), 64'd0);
    resetn = 1'b1;

    // Empty board: pure scan, fixed latency.
    clear_init();
    run("empty", 1'b0, H*12 + 2);

    // Single clear with a partial row above.
    clear_init();
    fill_row(23, 6'h05);
    init_b[22][3] = 6'h12;
    run("one", 1'b0, 0);

    // Two interleaved clears.
    clear_init();
    fill_row(23, 6'h01);
    fill_row(21, 6'h02);
    init_b[22][0] = 6'h07; init_b[22][9] = 6'h08;
    init_b[20][5] = 6'h3f;
    run("two", 1'b0, 0);

    // Tetris.
    clear_init();
    for (int y = 20; y < 24; y++) fill_row(y, 6'(y));
    run("tetris", 1'b0, 0);

    // Full clears reaching the hidden rows, including row 0.
    clear_init();
    fill_row(0, 6'h11);
    fill_row(1, 6'h22);
    init_b[2][4] = 6'h01;
    fill_row(23, 6'h33);
    run("top", 1'b0, 0);

    // Randomized boards.
    for (int t = 0; t < 8; t++) begin
      for (int y = 0; y < H; y++) begin
        int kind = int'($urandom_range(0, 3));
        for (int i = 0; i < W; i++) begin
          if (kind == 0) init_b[y][i] = 6'd0;
          else if (kind == 1) init_b[y][i] = 6'($urandom_range(1, 63));
          else init_b[y][i] = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        end
      end
      run($sformatf("rand%0d", t), 1'b0, 0);
    end

    // Reset during a row copy aborts at once; a fresh run then completes.
    clear_init();
    fill_row(23, 6'h05);
    init_b[22][3] = 6'h12;
    load_board();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!ram_wren && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("abort_copy_seen", 64'(ram_wren), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_wren", 64'(ram_wren), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    resetn = 1'b1;
    run("after_abort", 1'b0, 0);

    // Start held through the run: one run, then a restart only from idle.
    clear_init();
    fill_row(23, 6'h09);
    fill_row(22, 6'h0a);
    init_b[21][1] = 6'h02;
    run("hold", 1'b1, 0);
    @(negedge clk);
    check("hold_restart_busy", 64'(busy), 64'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("hold_second_done", 64'(done), 64'd1);
    check("hold_second_rc", 64'(rows_cleared), 64'd0);
    @(negedge clk);
    check_board("hold_second");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
